// File: rtl/switch_select_sync.sv
// -----------------------------------------------------------------------------
// switch_select_sync
//
// Purpose:
//   Card-select front end for a one-hot switch bank. The raw asynchronous
//   switches are brought into the clk domain through a two-flop synchroniser
//   and then debounced. Once a vector has settled, its binary position is
//   offered to the card register logic through a valid/ack handshake.
//   - Each physical press yields exactly one selection.
//   - The bank must return to all-zero before another selection is accepted.
//   - A settled multi-hot vector raises a sticky error flag.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   switch     raw asynchronous switch bank, N_SW bits
//   sel_ack    consumer accepts the current selection
//   sel_idx    encoded switch index, held stable while sel_valid is high
//   sel_valid  selection available
//   err        sticky flag: a settled vector was multi-hot
//
// Optional feature (macro SWITCH_SELECT_PRIORITY_EN):
//   When defined, a settled multi-hot vector in IDLE resolves to its lowest
//   set bit and is presented like a one-hot selection; err never sets.
//   When undefined, multi-hot sets err and waits for release.
// -----------------------------------------------------------------------------
module switch_select_sync #(
  parameter int N_SW      = 16,
  parameter int IDX_W     = 4,
  parameter int DB_CYCLES = 1000,
  parameter int DB_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SW-1:0]  switch,
  input  logic             sel_ack,
  output logic [IDX_W-1:0] sel_idx,
  output logic             sel_valid,
  output logic             err
);

  // Final count value; the vector is settled once the counter reaches it.
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  // True when exactly one bit of v is set.
  function automatic logic is_one_hot(input logic [N_SW-1:0] v);
    return (v != '0) && ((v & (v - N_SW'(1))) == '0);
  endfunction

  // Index of the lowest set bit of v (0 when v is zero).
  function automatic logic [IDX_W-1:0] low_idx(input logic [N_SW-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N_SW - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [N_SW-1:0]  s1_q, s2_q;
  logic [N_SW-1:0]  samp_q, samp_d;
  logic [DB_W-1:0]  cnt_q, cnt_d;
  logic             settled_q, settled_d;
  logic [N_SW-1:0]  vec_q, vec_d;
  state_e           state_q, state_d;
  logic             rel_q, rel_d;
  logic [IDX_W-1:0] sel_idx_q, sel_idx_d;
  logic             sel_valid_q, sel_valid_d;
  logic             err_q, err_d;

  // Debounce next state: restart the count whenever the synchronised vector
  // moves, saturate at DB_MAX while it stays put.
  always_comb begin
    samp_d = samp_q;
    cnt_d  = cnt_q;
    if (s2_q != samp_q) begin
      samp_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q < DB_MAX) begin
      cnt_d = cnt_q + DB_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    // The settled flag and its vector are registered together so the FSM
    // always acts on the pair that was actually judged stable.
    settled_d = (s2_q == samp_q) && (cnt_q == DB_MAX);
    vec_d     = samp_q;
  end

  // Synchroniser, debounce and settled-vector registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      samp_q    <= '0;
      cnt_q     <= '0;
      settled_q <= 1'b0;
      vec_q     <= '0;
    end else begin
      s1_q      <= switch;
      s2_q      <= s1_q;
      samp_q    <= samp_d;
      cnt_q     <= cnt_d;
      settled_q <= settled_d;
      vec_q     <= vec_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RELEASE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (settled_q && (vec_q != '0)) begin
`ifdef SWITCH_SELECT_PRIORITY_EN
          state_d = ST_HOLD;
`else
          if (is_one_hot(vec_q)) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_RELEASE;
          end
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // Without a release seen during HOLD, force a full release first.
        if (sel_ack) begin
          state_d = rel_q ? ST_IDLE : ST_RELEASE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_RELEASE: begin
        if (settled_q && (vec_q == '0)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      default: begin
        state_d = ST_RELEASE;
      end
    endcase
  end

  // FSM output logic: selection, valid, sticky error and release tracking.
  always_comb begin
    sel_idx_d   = sel_idx_q;
    sel_valid_d = sel_valid_q;
    err_d       = err_q;
    rel_d       = rel_q;
    case (state_q)
      ST_IDLE: begin
        if (settled_q && (vec_q != '0)) begin
`ifdef SWITCH_SELECT_PRIORITY_EN
          sel_idx_d   = low_idx(vec_q);
          sel_valid_d = 1'b1;
          err_d       = 1'b0;
          rel_d       = 1'b0;
`else
          if (is_one_hot(vec_q)) begin
            sel_idx_d   = low_idx(vec_q);
            sel_valid_d = 1'b1;
            err_d       = 1'b0;
            rel_d       = 1'b0;
          end else begin
            err_d = 1'b1;
          end
`endif
        end else begin
          sel_valid_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (sel_ack) begin
          sel_valid_d = 1'b0;
        end else if (settled_q && (vec_q == '0)) begin
          rel_d = 1'b1;
        end else begin
          rel_d = rel_q;
        end
      end
      ST_RELEASE: begin
        sel_valid_d = 1'b0;
      end
      default: begin
        sel_valid_d = 1'b0;
      end
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_idx_q   <= '0;
      sel_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rel_q       <= 1'b0;
    end else begin
      sel_idx_q   <= sel_idx_d;
      sel_valid_q <= sel_valid_d;
      err_q       <= err_d;
      rel_q       <= rel_d;
    end
  end

  assign sel_idx   = sel_idx_q;
  assign sel_valid = sel_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_switch_select_sync.sv
// -----------------------------------------------------------------------------
// tb_switch_select_sync
//
// Directed bench for switch_select_sync (N_SW=16, DB_CYCLES=4). A reference
// model keeps the raw switch samples per clock edge. It declares a vector
// settled at edge n when the DB_CYCLES+1 samples taken at edges n-3-DB..n-3
// are identical. This encodes the end-to-end latency of DB_CYCLES+3 edges;
// a reset restarts that window. The model's selection rules drive a
// per-cycle compare, and hand-computed literal checks pin the key scenarios.
// -----------------------------------------------------------------------------
module tb_switch_select_sync;

  localparam int N_SW = 16;
  localparam int IDX_W = 4;
  localparam int DB = 4;
  localparam int DB_W = 16;

  logic             clk;
  logic             rst;
  logic [N_SW-1:0]  switch;
  logic             sel_ack;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_valid;
  logic             err;

  int total = 0;
  int bad = 0;

  switch_select_sync #(
    .N_SW(N_SW), .IDX_W(IDX_W), .DB_CYCLES(DB), .DB_W(DB_W)
  ) dut (
    .clk(clk), .rst(rst), .switch(switch), .sel_ack(sel_ack),
    .sel_idx(sel_idx), .sel_valid(sel_valid), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [N_SW-1:0] hist [0:4095];
  int ecount = 0;
  int last_rst = -100;
  int m_mode = 2;          // 0 idle, 1 holding a selection, 2 awaiting release
  bit m_rel = 1'b0;
  bit m_valid = 1'b0;
  int m_idx = 0;
  bit m_err = 1'b0;
  bit model_live = 1'b0;

  always @(posedge clk) begin
    int lo;
    bit st;
    logic [N_SW-1:0] v;
    int low;
    st = 1'b0;
    v = '0;
    hist[ecount] = rst ? '0 : switch;
    if (rst) begin
      if (ecount >= 1) hist[ecount-1] = '0;
      if (ecount >= 2) hist[ecount-2] = '0;
      m_mode = 2; m_valid = 1'b0; m_idx = 0; m_err = 1'b0; m_rel = 1'b0;
      last_rst = ecount;
    end else begin
      lo = ecount - 3 - DB;
      if (lo >= 0 && lo >= last_rst - 2) begin
        st = 1'b1;
        v = hist[ecount-3];
        for (int i = lo; i <= ecount - 3; i++)
          if (hist[i] != v) st = 1'b0;
      end
      low = 0;
      for (int i = N_SW - 1; i >= 0; i--)
        if (v[i]) low = i;
      if (m_mode == 0) begin
        if (st && v != 0) begin
`ifdef SWITCH_SELECT_PRIORITY_EN
          m_idx = low; m_valid = 1'b1; m_err = 1'b0; m_rel = 1'b0; m_mode = 1;
`else
          if ($countones(v) == 1) begin
            m_idx = low; m_valid = 1'b1; m_err = 1'b0; m_rel = 1'b0; m_mode = 1;
          end else begin
            m_err = 1'b1; m_mode = 2;
          end
`endif
        end
      end else if (m_mode == 1) begin
        if (sel_ack) begin
          m_valid = 1'b0;
          m_mode = m_rel ? 0 : 2;
        end else if (st && v == 0) begin
          m_rel = 1'b1;
        end
      end else begin
        if (st && v == 0) m_mode = 0;
      end
    end
    ecount++;
    model_live = 1'b1;
  end

  // Per-cycle compare against the model.
  always @(posedge clk) begin
    #1;
    if (model_live) begin
      chk("cyc_valid", int'(sel_valid), int'(m_valid));
      chk("cyc_idx", int'(sel_idx), m_idx);
      chk("cyc_err", int'(err), int'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_valid(output int k);
    k = 0;
    while (!sel_valid && k < 30) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic idle_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_pulse();
    sel_ack = 1'b1;
    @(negedge clk);
    sel_ack = 1'b0;
  endtask

  initial begin
    int k;
    int nv;
    bit prev;
    int rises;
    rst = 1'b1;
    switch = '0;
    sel_ack = 1'b0;
    idle_n(3);
    chk("reset_valid", int'(sel_valid), 0);
    chk("reset_idx", int'(sel_idx), 0);
    chk("reset_err", int'(err), 0);
    rst = 1'b0;
    idle_n(8);

    // T1: first press, latency DB+3 edges after the change.
    switch = 16'h0020;
    wait_valid(k);
    chk("t1_latency_edges", k, 8);
    chk("t1_idx", int'(sel_idx), 5);
    chk("t1_err", int'(err), 0);
    @(negedge clk);
    idle_n(5);
    chk("t1_hold_valid", int'(sel_valid), 1);
    chk("t1_hold_idx", int'(sel_idx), 5);
    ack_pulse();
    switch = '0;
    idle_n(10);

    // T2: bouncing never selects; the steady value selects once.
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      switch = (((c / 2) % 2) == 0) ? 16'h0100 : 16'h0000;
      @(posedge clk);
      #1;
      if (sel_valid) nv++;
      @(negedge clk);
    end
    chk("t2_bounce_no_valid", nv, 0);
    switch = 16'h0100;
    wait_valid(k);
    chk("t2_valid_seen", int'(sel_valid), 1);
    chk("t2_idx", int'(sel_idx), 8);
    rises = 0;
    prev = sel_valid;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (sel_valid && !prev) rises++;
      prev = sel_valid;
    end
    chk("t2_single_valid", rises, 0);
    chk("t2_still_valid", int'(sel_valid), 1);
    @(negedge clk);

    // T3: ack while still pressed, no reselect until release.
    sel_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("t3_ack_drops_valid", int'(sel_valid), 0);
    @(negedge clk);
    sel_ack = 1'b0;
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (sel_valid) nv++;
    end
    chk("t3_no_reselect", nv, 0);
    @(negedge clk);
    switch = '0;
    idle_n(8);
    switch = 16'h8000;
    wait_valid(k);
    chk("t3_valid_seen", int'(sel_valid), 1);
    chk("t3_idx", int'(sel_idx), 15);
    @(negedge clk);
    ack_pulse();
    switch = '0;
    idle_n(8);

    // T4: multi-hot.
    switch = 16'h0011;
    idle_n(12);
`ifdef SWITCH_SELECT_PRIORITY_EN
    chk("t4_prio_valid", int'(sel_valid), 1);
    chk("t4_prio_idx", int'(sel_idx), 0);
    chk("t4_prio_err", int'(err), 0);
`else
    chk("t4_err", int'(err), 1);
    chk("t4_no_valid", int'(sel_valid), 0);
`endif
    switch = '0;
    idle_n(8);
    ack_pulse();
    switch = 16'h0002;
    wait_valid(k);
    chk("t4_legal_valid", int'(sel_valid), 1);
    chk("t4_legal_idx", int'(sel_idx), 1);
    chk("t4_legal_err", int'(err), 0);
    @(negedge clk);
    switch = '0;
    idle_n(8);
    ack_pulse();
    idle_n(2);

    // T5: switch held through reset is not a selection.
    switch = 16'h0004;
    idle_n(3);
    rst = 1'b1;
    idle_n(2);
    rst = 1'b0;
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (sel_valid) nv++;
    end
    chk("t5_no_valid_after_rst", nv, 0);
    @(negedge clk);
    switch = '0;
    idle_n(8);
    switch = 16'h0004;
    wait_valid(k);
    chk("t5_valid_seen", int'(sel_valid), 1);
    chk("t5_idx", int'(sel_idx), 2);
    @(negedge clk);
    switch = '0;
    idle_n(8);
    ack_pulse();
    idle_n(2);

    // T6: reset while holding drops the pending selection.
    switch = 16'h0020;
    wait_valid(k);
    chk("t6_valid_seen", int'(sel_valid), 1);
    chk("t6_idx_before", int'(sel_idx), 5);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_valid", int'(sel_valid), 0);
    chk("t6_rst_idx", int'(sel_idx), 0);
    chk("t6_rst_err", int'(err), 0);
    @(negedge clk);
    rst = 1'b0;
    sel_ack = 1'b1;
    @(negedge clk);
    sel_ack = 1'b0;
    nv = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (sel_valid) nv++;
    end
    chk("t6_ack_no_effect", nv, 0);
    @(negedge clk);
    idle_n(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
